// File: rtl/key_pio_in_pkg.sv
// Shared constants for the key/switch input PIO: register offsets and edge-type encodings.
// Latency: n/a (constants and a combinational helper only).
// Backpressure: n/a.
package key_pio_in_pkg;

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_RSVD    = 2'd1;
   localparam logic [1:0] ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] ADDR_EDGECAP = 2'd3;

   localparam int unsigned EDGE_RISE = 0;
   localparam int unsigned EDGE_FALL = 1;
   localparam int unsigned EDGE_ANY  = 2;

   // Per-bit edge detect of the conditioned input against its previous-cycle value.
   function automatic logic [31:0] edge_select(input int unsigned etype,
                                               input logic [31:0] cond,
                                               input logic [31:0] prev);
      logic [31:0] rise;
      logic [31:0] fall;
      rise = cond & ~prev;
      fall = ~cond & prev;
      case (etype)
         EDGE_RISE: edge_select = rise;
         EDGE_FALL: edge_select = fall;
         default:   edge_select = rise | fall;
      endcase
   endfunction

endpackage

// File: rtl/key_pio_in_debounce.sv
// Single-bit debouncer: output follows input only after it has differed for DEBOUNCE_CYCLES cycles.
// Latency: DEBOUNCE_CYCLES cycles from a stable input change to the output change.
// Backpressure: none; any excursion shorter than the window restarts the count.
`ifdef KEY_PIO_DEBOUNCE_EN
module pio_debounce_bit #(
   parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic din,
   output logic dout
);
   import key_pio_in_pkg::*;

   localparam int unsigned CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          cond_q, cond_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Count consecutive cycles of disagreement; flip the output when the window completes.
   always_comb begin
      cond_d = cond_q;
      cnt_d  = cnt_q;
      if (din == cond_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         cond_d = din;
         cnt_d  = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Debounce state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cond_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         cond_q <= cond_d;
         cnt_q  <= cnt_d;
      end
   end

   assign dout = cond_q;

endmodule
`endif

// File: rtl/key_pio_in.sv
// Avalon-MM input PIO: synchronised inputs, per-bit edge capture (W1C), masked level irq.
// Latency: read 1 cycle; in_port to DATA/EDGECAPTURE 2 cycles (+DEBOUNCE_CYCLES with KEY_PIO_DEBOUNCE_EN).
// Backpressure: none; slave always accepts, readdata registered every cycle from address.
module key_pio_in #(
   parameter int unsigned WIDTH           = 4,
   parameter int unsigned EDGE_TYPE       = 1,
   parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [WIDTH-1:0] writedata,
   output logic [WIDTH-1:0] readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);
   import key_pio_in_pkg::*;

   logic [WIDTH-1:0] sync1_q, sync1_d;
   logic [WIDTH-1:0] sync2_q, sync2_d;
   logic [WIDTH-1:0] prev_q, prev_d;
   logic [WIDTH-1:0] irqmask_q, irqmask_d;
   logic [WIDTH-1:0] edgecap_q, edgecap_d;
   logic [WIDTH-1:0] readdata_q, readdata_d;
   logic [WIDTH-1:0] cond;
   logic [WIDTH-1:0] edge_det;
   logic [WIDTH-1:0] clr_mask;
   logic             wr_en;

`ifdef KEY_PIO_DEBOUNCE_EN
   for (genvar i = 0; i < int'(WIDTH); i++) begin : g_db
      pio_debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_db (
         .clk     (clk),
         .reset_n (reset_n),
         .din     (sync2_q[i]),
         .dout    (cond[i])
      );
   end
`else
   assign cond = sync2_q;
`endif

   assign wr_en    = chipselect & ~write_n;
   assign edge_det = WIDTH'(edge_select(EDGE_TYPE, 32'(cond), 32'(prev_q)));

   // Next-state for the input path, mask, edge capture (set beats clear) and read mux.
   always_comb begin
      sync1_d   = in_port;
      sync2_d   = sync1_q;
      prev_d    = cond;
      irqmask_d = irqmask_q;
      clr_mask  = '0;
      if (wr_en && address == ADDR_IRQMASK) begin
         irqmask_d = writedata;
      end
      if (wr_en && address == ADDR_EDGECAP) begin
         clr_mask = writedata;
      end
      edgecap_d = (edgecap_q & ~clr_mask) | edge_det;
      case (address)
         ADDR_DATA:    readdata_d = cond;
         ADDR_IRQMASK: readdata_d = irqmask_q;
         ADDR_EDGECAP: readdata_d = edgecap_q;
         default:      readdata_d = '0;
      endcase
   end

   // State registers, all cleared asynchronously.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         prev_q     <= '0;
         irqmask_q  <= '0;
         edgecap_q  <= '0;
         readdata_q <= '0;
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         prev_q     <= prev_d;
         irqmask_q  <= irqmask_d;
         edgecap_q  <= edgecap_d;
         readdata_q <= readdata_d;
      end
   end

   assign readdata = readdata_q;
   assign irq      = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_key_pio_in.sv
`timescale 1ns/1ps
module tb_key_pio_in;

   localparam int W  = 4;
   localparam int DB = 8;

   logic           clk = 1'b0;
   logic           reset_n;
   logic [1:0]     address;
   logic           chipselect;
   logic           write_n;
   logic [W-1:0]   writedata;
   logic [W-1:0]   in_port;
   logic [2:0][W-1:0] rd;
   logic [2:0]     irq;

   int n_assert = 0;
   int n_fail   = 0;
   bit model_on = 1'b0;
   int hold;

   // Reference model: inputs sampled at each edge (h[0] newest), per-DUT mask/capture/readback.
   logic [W-1:0] h [4];
   logic [W-1:0] m_mask [3];
   logic [W-1:0] m_ecap [3];
   logic [W-1:0] m_rd   [3];

   // DUT index doubles as edge type: 0 rising, 1 falling, 2 any.
   key_pio_in #(.WIDTH(W), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(DB)) u_rise (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(rd[0]), .in_port(in_port), .irq(irq[0]));
   key_pio_in #(.WIDTH(W), .EDGE_TYPE(1), .DEBOUNCE_CYCLES(DB)) u_fall (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(rd[1]), .in_port(in_port), .irq(irq[1]));
   key_pio_in #(.WIDTH(W), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(DB)) u_any (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(rd[2]), .in_port(in_port), .irq(irq[2]));

   always #5 clk = ~clk;

   function automatic logic [W-1:0] edges(input int et, input logic [W-1:0] c, input logic [W-1:0] p);
      if (et == 0)      return c & ~p;
      else if (et == 1) return ~c & p;
      else              return c ^ p;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) h[i] = '0;
      for (int i = 0; i < 3; i++) begin
         m_mask[i] = '0;
         m_ecap[i] = '0;
         m_rd[i]   = '0;
      end
   endtask

   task automatic tick();
      logic [W-1:0] clr;
      @(posedge clk);
      if (!reset_n) begin
         model_reset();
      end else begin
         clr = (chipselect && !write_n && address == 2'd3) ? writedata : '0;
         for (int i = 0; i < 3; i++) begin
            case (address)
               2'd0:    m_rd[i] = h[1];
               2'd2:    m_rd[i] = m_mask[i];
               2'd3:    m_rd[i] = m_ecap[i];
               default: m_rd[i] = '0;
            endcase
            m_ecap[i] = (m_ecap[i] & ~clr) | edges(i, h[1], h[2]);
            if (chipselect && !write_n && address == 2'd2) m_mask[i] = writedata;
         end
         h[3] = h[2];
         h[2] = h[1];
         h[1] = h[0];
         h[0] = in_port;
      end
      #1;
      if (model_on) begin
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("model_rd[%0d]", i), 32'(rd[i]), 32'(m_rd[i]));
            chk($sformatf("model_irq[%0d]", i), 32'(irq[i]), 32'(|(m_ecap[i] & m_mask[i])));
         end
      end
   endtask

   task automatic idle();
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
   endtask

   task automatic wr(input logic [1:0] a, input logic [W-1:0] d);
      chipselect = 1'b1;
      write_n    = 1'b0;
      address    = a;
      writedata  = d;
      tick();
      idle();
   endtask

   task automatic rd_at(input logic [1:0] a);
      address = a;
      tick();
   endtask

   initial begin
      model_reset();
`ifdef KEY_PIO_DEBOUNCE_EN
      hold     = DB + 4;
      model_on = 1'b0;
`else
      hold     = 4;
      model_on = 1'b1;
`endif
      // Reset with all inputs high.
      reset_n = 1'b0;
      in_port = 4'hF;
      address = 2'd0;
      idle();
      tick();
      chk("reset_irq_fall", 32'(irq[1]), 0);
      chk("reset_rd_fall", 32'(rd[1]), 0);
      tick();
      reset_n = 1'b1;
      repeat (hold) begin
         tick();
         chk("irq_quiet_after_reset", 32'(irq[1]), 0);
      end
      rd_at(2'd0); chk("data_after_reset", 32'(rd[1]), 32'hF);
      rd_at(2'd1); chk("reserved_reads_0", 32'(rd[1]), 0);
      rd_at(2'd2); chk("mask_after_reset", 32'(rd[1]), 0);
      rd_at(2'd3); chk("ecap_after_reset", 32'(rd[1]), 0);
      wr(2'd0, 4'h5);
      wr(2'd1, 4'h5);
      rd_at(2'd0); chk("data_write_ignored", 32'(rd[1]), 32'hF);
      wr(2'd3, 4'hF);

`ifndef KEY_PIO_DEBOUNCE_EN
      // Falling edge on bit 0: captured at k+2, visible on readback one cycle later.
      address = 2'd3;
      in_port = 4'hE;
      tick(); tick();
      chk("ecap_before_k2", 32'(rd[1]), 0);
      tick(); tick();
      chk("ecap_fall_bit0", 32'(rd[1]), 32'h1);
      chk("irq_masked_off", 32'(irq[1]), 0);
      wr(2'd2, 4'h1);
      chk("irq_after_mask", 32'(irq[1]), 1);

      // Clear coinciding with a newly detected edge: set wins.
      in_port = 4'hF;
      repeat (4) tick();
      in_port = 4'hE;
      tick(); tick();
      chipselect = 1'b1; write_n = 1'b0; address = 2'd3; writedata = 4'h1;
      tick();
      idle();
      chk("set_beats_clear_irq", 32'(irq[1]), 1);
      rd_at(2'd3); chk("set_beats_clear_ecap", 32'(rd[1]), 32'h1);
      wr(2'd3, 4'h1);
      chk("lone_clear_irq", 32'(irq[1]), 0);
      rd_at(2'd3); chk("lone_clear_ecap", 32'(rd[1]), 0);

      // Any-edge DUT: bit 2 toggles, cleared between toggles.
      in_port = 4'hA;
      repeat (10) tick();
      wr(2'd3, 4'hF);
      in_port = 4'hE;
      repeat (10) tick();
      rd_at(2'd3); chk("any_rise_bit2", 32'(rd[2]), 32'h4);
      wr(2'd3, 4'hF);
      in_port = 4'hA;
      repeat (10) tick();
      rd_at(2'd3); chk("any_fall_bit2", 32'(rd[2]), 32'h4);
      wr(2'd3, 4'hF);

      // Random bus and input traffic against the model.
      repeat (400) begin
         in_port    = W'($urandom);
         address    = 2'($urandom);
         chipselect = 1'($urandom);
         write_n    = 1'($urandom);
         writedata  = W'($urandom);
         tick();
      end
      idle();
`else
      // Short low pulse on bit 1 is filtered out.
      address = 2'd0;
      in_port = 4'hD;
      repeat (5) tick();
      in_port = 4'hF;
      repeat (20) tick();
      rd_at(2'd0); chk("db_short_data", 32'(rd[1]), 32'hF);
      rd_at(2'd3); chk("db_short_ecap", 32'(rd[1]), 0);

      // Long low pulse: DATA changes after DEBOUNCE_CYCLES + 2 edges.
      address = 2'd0;
      in_port = 4'hD;
      repeat (DB + 2) tick();
      chk("db_long_data_early", 32'(rd[1]), 32'hF);
      tick();
      chk("db_long_data", 32'(rd[1]), 32'hD);
      repeat (9) tick();
      in_port = 4'hF;
      repeat (hold) tick();
      rd_at(2'd3); chk("db_long_ecap", 32'(rd[1]), 32'h2);
`endif

      // Fill capture and mask, then reset mid-cycle: irq must drop without a clock edge.
      wr(2'd2, 4'hF);
      in_port = 4'h0;
      repeat (hold) tick();
      in_port = 4'hF;
      repeat (hold) tick();
      in_port = 4'h0;
      repeat (hold) tick();
      rd_at(2'd3);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("full_ecap[%0d]", i), 32'(rd[i]), 32'hF);
         chk($sformatf("full_irq[%0d]", i), 32'(irq[i]), 1);
      end
      #2;
      reset_n = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("async_irq[%0d]", i), 32'(irq[i]), 0);
         chk($sformatf("async_rd[%0d]", i), 32'(rd[i]), 0);
      end
      model_reset();
      tick(); tick();
      reset_n = 1'b1;
      repeat (hold) tick();
      rd_at(2'd0); for (int i = 0; i < 3; i++) chk($sformatf("post_rst_data[%0d]", i), 32'(rd[i]), 0);
      rd_at(2'd2); for (int i = 0; i < 3; i++) chk($sformatf("post_rst_mask[%0d]", i), 32'(rd[i]), 0);
      rd_at(2'd3); for (int i = 0; i < 3; i++) chk($sformatf("post_rst_ecap[%0d]", i), 32'(rd[i]), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/key_pio_in.md
# key_pio_in

Avalon-MM slave input port: the read-side counterpart of the LED output register block on the same Nios II system bus. It samples an external input bus (push-buttons, switches), synchronises it, and exposes it at register offset 0. Configured edges are latched into a per-bit edge-capture register, and a level interrupt is raised to the CPU through a per-bit mask.

## Interface
- WIDTH, 4: number of input bits (1..32).
- EDGE_TYPE, 1: captured edge; 0 = rising, 1 = falling, 2 = any.
- DEBOUNCE_CYCLES, 50000: stable-sample count required before a bit changes (used only with debounce compiled in; ≥2).

Ports (reset reset_n, asynchronous, active-low; clock clk):
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  2  register offset.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  WIDTH  write data.
- readdata  out  WIDTH  registered read data.
- in_port  in  WIDTH  asynchronous external inputs.
- irq  out  1  interrupt request, active-high level.

## Operation
- Register map:
  - 0 DATA (RO): current conditioned input value.
  - 1: reserved, reads 0.
  - 2 IRQMASK (RW).
  - 3 EDGECAPTURE (R, write-1-to-clear per bit).
- Writes to offsets 0 and 1 are ignored.
- Input path per bit: 2-flop synchroniser sync1 → sync2, then optional debounce (Configuration) → cond. prev holds cond from the previous cycle.
- Edge detect, combinational on cond vs prev:
  - rise = cond & ~prev
  - fall = ~cond & prev
  - any = rise | fall
  - EDGE_TYPE selects which of these is used.
- EDGECAPTURE bit: set on a detected edge; cleared by a write to offset 3 with writedata[i] = 1; otherwise holds.
  - Edge detected in the same cycle as a clear of that bit: set wins.
- IRQMASK: loaded from writedata on `chipselect & ~write_n & address == 2`.
- irq = |(EDGECAPTURE & IRQMASK). Combinational from registers only; no path from in_port or the bus.
- readdata: registered every clk from the mux of the current address, regardless of chipselect.
- Reset values: sync1, sync2, prev and cond are all 0; IRQMASK = 0; EDGECAPTURE = 0; readdata = 0; irq = 0.
- Reset mid-operation:
  - All state clears asynchronously; no edge is captured from the reset release itself.
  - After reset, prev = 0. An input held high therefore produces one rising edge after release (EDGE_TYPE 0/2). This is intended and documented for software, which clears EDGECAPTURE before enabling the mask.

## Timing
- Read latency is 1: readdata is valid in the cycle after address/chipselect are presented (bus fabric configured for readLatency 1).
- Input to DATA, no debounce: an in_port change stable before edge k gives sync2 at k+1 and cond at k+1. It is visible in readdata after edge k+2.
- Input to EDGECAPTURE and irq: the bit sets at edge k+2, so irq rises after edge k+2.
- Clear: a write at edge w clears the bit at w; irq falls in the same cycle if no other masked bit is set.
- Mask write: takes effect on irq immediately after the writing edge.
- Glitches shorter than one clk may be missed; this is acceptable.

## Configuration
- KEY_PIO_DEBOUNCE_EN defined:
  - A per-bit debouncer sits between sync2 and cond.
  - cond[i] changes only after sync2[i] has differed from cond[i] for DEBOUNCE_CYCLES consecutive cycles. A shorter excursion reloads the counter.
  - This adds DEBOUNCE_CYCLES cycles to all input latencies above.
- KEY_PIO_DEBOUNCE_EN undefined: cond = sync2; DEBOUNCE_CYCLES is ignored.

## Structure
- Shared package:
  - register offset constants (ADDR_DATA = 0, ADDR_IRQMASK = 2, ADDR_EDGECAP = 3);
  - EDGE_TYPE encodings (EDGE_RISE, EDGE_FALL, EDGE_ANY).
- Sub-module pio_debounce_bit (single bit, counter width = clog2(DEBOUNCE_CYCLES)), instantiated WIDTH times in a generate loop. It exists only under KEY_PIO_DEBOUNCE_EN.

## Test plan
- Reset with in_port = 4'hF, EDGE_TYPE 1: read offsets 0/2/3 → 4'hF / 0 / 0; irq = 0 throughout.
- in_port 4'hF → 4'hE (falling bit 0), no debounce: EDGECAPTURE = 4'h1 at edge k+2; irq stays 0 with IRQMASK = 0. Writing IRQMASK = 4'h1 raises irq on the next cycle.
- Write 4'h1 to offset 3 in the same cycle a new falling edge on bit 0 is detected → bit 0 remains 1 and irq stays 1. A lone write of 4'h1 afterwards → EDGECAPTURE = 0, irq = 0.
- EDGE_TYPE 2, bit 2 toggles 0 → 1 → 0 with 10-cycle spacing, cleared between toggles → two separate captures, both 4'h4.
- KEY_PIO_DEBOUNCE_EN, DEBOUNCE_CYCLES = 8:
  - a 5-cycle low pulse on bit 1 → DATA unchanged, no capture;
  - a 20-cycle low pulse → DATA bit 1 = 0 after 8 + 2 cycles, and capture set.
- Assert reset_n while EDGECAPTURE = 4'hF and IRQMASK = 4'hF → irq drops asynchronously and all registers read 0 after release.
